// File: rtl/mux_2_to_1.sv
// mux_2_to_1: two-input selector with registered copy, valid flag and saturating select-change count
module mux_2_to_1 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_select,
   output logic [WIDTH-1:0] o_y,
   output logic [WIDTH-1:0] o_y_q,
   output logic             o_y_valid,
   output logic [CNT_W-1:0] o_sel_changes
);
   logic [WIDTH-1:0] r_y_q;
   logic             r_valid;
   logic             r_sel_prev;
   logic [CNT_W-1:0] r_cnt;
   logic             w_toggle;
   assign o_y = i_select ? i_b : i_a;
   assign w_toggle = r_valid && (i_select != r_sel_prev) && !(&r_cnt);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_y_q      <= '0;
         r_valid    <= 1'b0;
         r_sel_prev <= 1'b0;
         r_cnt      <= '0;
      end else begin
         r_y_q      <= o_y;
         r_valid    <= 1'b1;
         r_sel_prev <= i_select;
         r_cnt      <= w_toggle ? r_cnt + 1'b1 : r_cnt;
      end
   assign o_y_q         = r_y_q;
   assign o_y_valid     = r_valid;
   assign o_sel_changes = r_cnt;
endmodule

// File: tb/tb_mux_2_to_1.sv
// tb_mux_2_to_1: directed vectors for the 1-bit and 8-bit selector configurations
module tb_mux_2_to_1;
   typedef struct packed {logic a; logic b; logic s; logic y;} vec_t;
   logic clk = 1'b0, clk_en = 1'b0, rst_n = 1'b0;
   logic a1 = 1'b0, b1 = 1'b0, s1 = 1'b0, s8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic y1, yq1, v1, y8v;
   logic [1:0] c1;
   logic [7:0] y8, yq8, c8;
   int total = 0, passed = 0;
   vec_t vecs [14];

   always #5 if (clk_en) clk = ~clk;

   mux_2_to_1 #(.WIDTH(1), .CNT_W(2)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(a1), .i_b(b1), .i_select(s1),
      .o_y(y1), .o_y_q(yq1), .o_y_valid(v1), .o_sel_changes(c1));
   mux_2_to_1 #(.WIDTH(8), .CNT_W(8)) u8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_a(a8), .i_b(b8), .i_select(s8),
      .o_y(y8), .o_y_q(yq8), .o_y_valid(y8v), .o_sel_changes(c8));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs = '{4'b0000, 4'b1001, 4'b1010, 4'b1111, 4'b0111, 4'b0100,
               4'b0000, 4'b0010, 4'b0100, 4'b0111, 4'b1001, 4'b1010, 4'b1101, 4'b1111};
      #1;
      chk("rst_yq1", yq1, 0);
      chk("rst_valid1", v1, 0);
      chk("rst_cnt1", c1, 0);
      chk("rst_yq8", yq8, 0);
      chk("rst_valid8", y8v, 0);
      chk("rst_cnt8", c8, 0);
      a8 = 8'h3C; b8 = 8'hA5; s8 = 1'b1;
      #1 chk("rst_y8_tracks", y8, 8'hA5);
      rst_n = 1'b1;
      for (int i = 0; i < 14; i++) begin
         a1 = vecs[i].a; b1 = vecs[i].b; s1 = vecs[i].s;
         #5 chk($sformatf("comb_vec%0d", i), y1, vecs[i].y);
      end
      chk("idle_valid1", v1, 0);
      a8 = 8'h5A; b8 = 8'hC3; s8 = 1'b0;
      #1 chk("y8_a", y8, 8'h5A);
      clk_en = 1'b1;
      tick();
      chk("lat_yq_a", yq8, 8'h5A);
      chk("lat_valid", y8v, 1);
      chk("lat_cnt0", c8, 0);
      s8 = 1'b1;
      #1 chk("y8_b_comb", y8, 8'hC3);
      chk("yq_holds", yq8, 8'h5A);
      tick();
      chk("lat_yq_b", yq8, 8'hC3);
      chk("lat_cnt1", c8, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_yq", yq8, 0);
      chk("async_valid", y8v, 0);
      chk("async_cnt", c8, 0);
      b8 = 8'h77;
      #1 chk("rst_y_tracks", y8, 8'h77);
      rst_n = 1'b1;
      tick();
      chk("rel_valid", y8v, 1);
      chk("rel_yq", yq8, 8'h77);
      chk("rel_not_counted", c8, 0);
      for (int i = 0; i < 5; i++) begin
         s8 = ~s8;
         tick();
      end
      chk("cnt5", c8, 5);
      s8 = ~s8; #1 s8 = ~s8;
      tick();
      chk("glitch_zero", c8, 5);
      s8 = ~s8; #1 s8 = ~s8; #1 s8 = ~s8;
      tick();
      chk("glitch_once", c8, 6);
      a1 = 1'b0; b1 = 1'b1;
      tick();
      chk("sat_start", c1, 0);
      for (int i = 0; i < 10; i++) begin
         s1 = ~s1;
         tick();
         if (i == 1) chk("sat_cnt2", c1, 2);
      end
      chk("sat_cnt3", c1, 3);
      chk("yq1_follows", yq1, s1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
